// File: rtl/mmu_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_array_if
//  Purpose  : Handshake bundle for the weight-stationary matrix unit. Carries
//             the weight-row load channel, the activation-vector channel, the
//             result channel and the busy flag.
//  Signals  : w_load_valid / w_load_row / w_load_ready  - weight row load
//             a_valid / a_vec / a_ready                 - activation vector
//             out_valid / out_vec                       - result vector
//             busy                                      - array occupied
//  Modports : master - drives the load/activation channels (client side)
//             slave  - the array itself
//  Revision : 1.0 - initial release
// ============================================================================
interface mmu_array_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 16
);
    logic            w_load_valid;
    logic [N*DW-1:0] w_load_row;
    logic            w_load_ready;
    logic            a_valid;
    logic [N*DW-1:0] a_vec;
    logic            a_ready;
    logic            out_valid;
    logic [N*AW-1:0] out_vec;
    logic            busy;

    modport master (
        output w_load_valid, w_load_row, a_valid, a_vec,
        input  w_load_ready, a_ready, out_valid, out_vec, busy
    );

    modport slave (
        input  w_load_valid, w_load_row, a_valid, a_vec,
        output w_load_ready, a_ready, out_valid, out_vec, busy
    );
endinterface
`default_nettype wire

// File: rtl/mmu_array.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_array
//  Purpose  : NxN weight-stationary systolic array computing
//             y[j] = sum_i a[i] * W[i][j]. Activations flow right, partial
//             sums flow down. Fixed latency of 2N cycles from acceptance to
//             out_valid, one vector per cycle sustained.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-low reset
//             bus   - mmu_array_if.slave (weight load, activation, result,
//                     busy)
//  Config   : MMU_ARRAY_SAT_EN - when defined every PE add saturates to the
//             signed AW-bit range; otherwise sums wrap modulo 2^AW.
//  Revision : 1.0 - initial release
// ============================================================================
module mmu_array #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic       clk,
    input  logic       reset,
    mmu_array_if.slave bus
);
    localparam int c_RW = (N > 1) ? $clog2(N) : 1;
    localparam int c_CW = $clog2(2 * N + 1);
    localparam int c_VL = 2 * N;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_READY = 2'd1,
        S_DRAIN = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_RW-1:0]      r_row, w_row_nxt;
    logic                 r_rst_done;
    logic [c_CW-1:0]      r_inflight;
    logic [c_VL-1:0]      r_vsr;
    logic                 r_out_valid;
    logic [N*AW-1:0]      r_out_vec;
    logic                 w_load_ready, w_a_ready, w_row_acc, w_acc, w_empty;
    logic signed [DW-1:0] r_w    [N][N];
    logic signed [DW-1:0] w_act  [N][N];   // activation input of PE(i,j)
    logic signed [AW-1:0] w_psum [N][N];   // registered partial sum of PE(i,j)
    logic signed [AW-1:0] w_col  [N];      // deskewed column results

    assign w_empty = (r_inflight == '0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_row      <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_rst_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_load_ready = 1'b0;
        w_a_ready    = 1'b0;
        case (r_state)
            // Ready is held off until the first edge after reset release.
            S_EMPTY: w_load_ready = r_rst_done;
            S_LOAD:  w_load_ready = 1'b1;
            S_READY: begin
                // A pending weight load always beats a new vector.
                w_a_ready    = !bus.w_load_valid;
                w_load_ready = w_empty;
                if (bus.w_load_valid && !w_empty) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_LOAD;
                    w_row_nxt   = '0;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Row acceptance from EMPTY, READY or LOAD: r_row is 0 in the first two.
        w_row_acc = bus.w_load_valid && w_load_ready;
        if (w_row_acc) begin
            if (r_row == c_RW'(N - 1)) begin
                w_state_nxt = S_READY;
                w_row_nxt   = '0;
            end else begin
                w_state_nxt = S_LOAD;
                w_row_nxt   = r_row + c_RW'(1);
            end
        end
        w_acc = bus.a_valid && w_a_ready;
    end

    // ------------------------------------------------------------------
    // Stationary weights: written only while no vector is in flight
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else if (w_row_acc) begin
            for (int r = 0; r < N; r++) begin
                if (r_row == c_RW'(r)) begin
                    for (int c = 0; c < N; c++) begin
                        r_w[r][c] <= bus.w_load_row[c*DW +: DW];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: lane i passes through i+1 registers, so PE(i,0) sees
    // a[i] one cycle after PE(i-1,0) saw a[i-1]. Bubbles inject zeros.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [DW-1:0] r_sk [0:i];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k <= i; k++) r_sk[k] <= '0;
            end else begin
                r_sk[0] <= w_acc ? $signed(bus.a_vec[i*DW +: DW]) : '0;
                for (int k = 1; k <= i; k++) r_sk[k] <= r_sk[k-1];
            end
        end
        assign w_act[i][0] = r_sk[i];
    end

    // ------------------------------------------------------------------
    // Processing elements
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [2*DW-1:0] w_prod;
            logic signed [AW-1:0]   w_prod_ext, w_psum_in, w_sum, r_psum;

            if (i == 0) begin : g_top
                assign w_psum_in = '0;
            end else begin : g_mid
                assign w_psum_in = w_psum[i-1][j];
            end

            // Operands widened first so the product is the full 2*DW bits.
            assign w_prod     = (2*DW)'(w_act[i][j]) * (2*DW)'(r_w[i][j]);
            assign w_prod_ext = AW'(w_prod);

`ifdef MMU_ARRAY_SAT_EN
            logic signed [AW:0] w_wide;
            assign w_wide = (AW+1)'(w_psum_in) + (AW+1)'(w_prod_ext);
            always_comb begin
                w_sum = w_wide[AW-1:0];
                if (w_wide[AW] != w_wide[AW-1]) begin
                    w_sum = w_wide[AW] ? {1'b1, {(AW-1){1'b0}}}
                                       : {1'b0, {(AW-1){1'b1}}};
                end
            end
`else
            assign w_sum = w_psum_in + w_prod_ext;
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) r_psum <= '0;
                else        r_psum <= w_sum;
            end
            assign w_psum[i][j] = r_psum;

            // The last column has no right-hand neighbour to feed.
            if (j < N - 1) begin : g_fwd
                logic signed [DW-1:0] r_act;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) r_act <= '0;
                    else        r_act <= w_act[i][j];
                end
                assign w_act[i][j+1] = r_act;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column j waits N-1-j cycles so all columns align
    // ------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_dsk
        if (j == N - 1) begin : g_pass
            assign w_col[j] = w_psum[N-1][j];
        end else begin : g_dly
            localparam int c_DLY = N - 1 - j;
            logic signed [AW-1:0] r_ds [0:c_DLY-1];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < c_DLY; k++) r_ds[k] <= '0;
                end else begin
                    r_ds[0] <= w_psum[N-1][j];
                    for (int k = 1; k < c_DLY; k++) r_ds[k] <= r_ds[k-1];
                end
            end
            assign w_col[j] = r_ds[c_DLY-1];
        end
    end

    // ------------------------------------------------------------------
    // Valid tracking, in-flight count and registered output.
    // A vector leaves the in-flight count on the edge that raises out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsr       <= '0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_inflight  <= '0;
        end else begin
            r_vsr       <= {r_vsr[c_VL-2:0], w_acc};
            r_out_valid <= r_vsr[c_VL-1];
            if (r_vsr[c_VL-1]) begin
                for (int c = 0; c < N; c++) r_out_vec[c*AW +: AW] <= w_col[c];
            end
            if (w_acc && !r_vsr[c_VL-1]) begin
                r_inflight <= r_inflight + c_CW'(1);
            end else if (!w_acc && r_vsr[c_VL-1]) begin
                r_inflight <= r_inflight - c_CW'(1);
            end
        end
    end

    assign bus.w_load_ready = w_load_ready;
    assign bus.a_ready      = w_a_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_vec      = r_out_vec;
    assign bus.busy         = (r_state == S_LOAD) || (r_state == S_DRAIN) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_mmu_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmu_array
//  Purpose  : Self-checking bench for mmu_array (N=2, DW=8, AW=16).
//             Expected result vectors and acceptance cycles are queued when a
//             vector is accepted and compared when out_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_array;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 16;
`ifdef MMU_ARRAY_SAT_EN
    localparam longint c_MAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint c_MIN = -(longint'(1) << (AW - 1));
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errs;

    logic signed [DW-1:0] tb_w [N][N];
    int                   tb_row;
    logic [N*AW-1:0]      exp_q [$];
    int                   acc_q [$];
    logic [N*AW-1:0]      last_exp;

    mmu_array_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    mmu_array #(.N(N), .DW(DW), .AW(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] vec2(input int a0, input int a1);
        logic [N*DW-1:0] v;
        v = {DW'(a1), DW'(a0)};
        return v;
    endfunction

    // Reference: column sums with per-step wrap or saturation.
    function automatic logic [N*AW-1:0] model(input logic [N*DW-1:0] av);
        logic [N*AW-1:0]      res;
        logic signed [DW-1:0] ai;
        longint               acc;
        longint               p;
        res = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                ai  = av[i*DW +: DW];
                p   = longint'(ai) * longint'(tb_w[i][j]);
                acc = acc + p;
`ifdef MMU_ARRAY_SAT_EN
                if (acc > c_MAX) acc = c_MAX;
                else if (acc < c_MIN) acc = c_MIN;
`else
                acc = acc & ((longint'(1) << AW) - 1);
                if (acc >= (longint'(1) << (AW - 1))) acc = acc - (longint'(1) << AW);
`endif
            end
            res[j*AW +: AW] = acc[AW-1:0];
        end
        return res;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_out_valid", 64'(1), 64'(0));
            end else begin
                last_exp = exp_q.pop_front();
                check_value("out_vec", 64'(bus.out_vec), 64'(last_exp));
                check_value("latency", 64'(cyc - acc_q.pop_front()), 64'(2 * N));
            end
        end
    end

    // One clock cycle of stimulus; handshakes are resolved just before the edge.
    task automatic step(input logic wv, input logic [N*DW-1:0] wrow,
                        input logic av, input logic [N*DW-1:0] avec,
                        output logic wa, output logic aa);
        @(negedge clk);
        bus.w_load_valid = wv;
        bus.w_load_row   = wrow;
        bus.a_valid      = av;
        bus.a_vec        = avec;
        #1;
        wa = wv & bus.w_load_ready;
        aa = av & bus.a_ready;
        if (aa) begin
            exp_q.push_back(model(avec));
            acc_q.push_back(cyc + 1);
        end
        if (wa) begin
            for (int j = 0; j < N; j++) tb_w[tb_row][j] = wrow[j*DW +: DW];
            tb_row = (tb_row == N - 1) ? 0 : tb_row + 1;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        logic wa, aa;
        step(1'b0, '0, 1'b0, '0, wa, aa);
    endtask

    task automatic load_row(input logic [N*DW-1:0] row);
        logic wa, aa;
        wa = 1'b0;
        for (int k = 0; k < 40 && !wa; k++) step(1'b1, row, 1'b0, '0, wa, aa);
        check_value("load_row_accepted", 64'(wa), 64'(1));
    endtask

    task automatic send_vec(input logic [N*DW-1:0] v);
        logic wa, aa;
        step(1'b0, '0, 1'b1, v, wa, aa);
        check_value("a_accepted", 64'(aa), 64'(1));
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) idle();
        check_value("drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.w_load_valid = 1'b0;
        bus.a_valid      = 1'b0;
        exp_q.delete();
        acc_q.delete();
        tb_row = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tb_w[r][c] = '0;
        #1;
        check_value("rst_out_valid",    64'(bus.out_valid),    64'(0));
        check_value("rst_out_vec",      64'(bus.out_vec),      64'(0));
        check_value("rst_a_ready",      64'(bus.a_ready),      64'(0));
        check_value("rst_busy",         64'(bus.busy),         64'(0));
        check_value("rst_w_load_ready", 64'(bus.w_load_ready), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_value("rel_w_load_ready_pre_edge", 64'(bus.w_load_ready), 64'(0));
        @(negedge clk);
        #1;
        check_value("rel_w_load_ready", 64'(bus.w_load_ready), 64'(1));
        check_value("rel_a_ready",      64'(bus.a_ready),      64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete (checks %0d, errors %0d)", n_checks, n_errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic            wa, aa;
        int              nacc;
        logic [N*DW-1:0] v;
        clk = 1'b0;
        reset = 1'b1;
        cyc = 0;
        n_checks = 0;
        n_errs = 0;
        tb_row = 0;
        last_exp = '0;
        bus.w_load_valid = 1'b0;
        bus.w_load_row   = '0;
        bus.a_valid      = 1'b0;
        bus.a_vec        = '0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) tb_w[r][c] = '0;

        // Power-on reset
        apply_reset();

        // Basic product: W=[1,2],[3,4], a=[5,6] -> [23,34]
        load_row(vec2(1, 2));
        load_row(vec2(3, 4));
        send_vec(vec2(5, 6));
        #1 check_value("busy_in_flight", 64'(bus.busy), 64'(1));
        wait_drain();
        #1;
        check_value("busy_after_out",  64'(bus.busy),      64'(0));
        check_value("out_valid_pulse", 64'(bus.out_valid), 64'(0));
        check_value("out_vec_hold",    64'(bus.out_vec),   64'(last_exp));

        // Back-to-back stream -> [1,2],[3,4],[8,12] on consecutive cycles
        send_vec(vec2(1, 0));
        send_vec(vec2(0, 1));
        send_vec(vec2(2, 2));
        wait_drain();

        // Simultaneous offer in READY: the weight row wins
        step(1'b1, vec2(-1, 2), 1'b1, vec2(5, 5), wa, aa);
        check_value("contest_a_acc", 64'(aa), 64'(0));
        check_value("contest_w_acc", 64'(wa), 64'(1));
        load_row(vec2(3, -4));
        repeat (2 * N + 2) idle();
        send_vec(vec2(7, -3));
        wait_drain();

        // Weight load while vectors are in flight: drain with old weights
        send_vec(vec2(4, -2));
        send_vec(vec2(-6, 9));
        step(1'b1, vec2(2, -1), 1'b1, vec2(1, 1), wa, aa);
        check_value("drain_entry_w_acc", 64'(wa), 64'(0));
        check_value("drain_entry_a_acc", 64'(aa), 64'(0));
        nacc = 0;
        for (int k = 0; k < 40 && !wa; k++) begin
            step(1'b1, vec2(2, -1), 1'b1, vec2(1, 1), wa, aa);
            if (aa) nacc++;
        end
        check_value("drain_no_vec_acc", 64'(nacc), 64'(0));
        check_value("drain_row_acc",    64'(wa),   64'(1));
        check_value("drain_results_out", 64'(exp_q.size()), 64'(0));
        load_row(vec2(5, 3));
        send_vec(vec2(3, 4));
        wait_drain();

        // Extreme operands: wrap or saturate
        load_row(vec2(-128, -128));
        load_row(vec2(-128, -128));
        send_vec(vec2(-128, -128));
        wait_drain();

        // Random weights and a gappy random stream
        load_row((N*DW)'($urandom));
        load_row((N*DW)'($urandom));
        for (int k = 0; k < 16; k++) begin
            v = (N*DW)'($urandom);
            step(1'b0, '0, 1'($urandom_range(0, 1)), v, wa, aa);
        end
        wait_drain();

        // Reset with vectors in flight: no result may appear afterwards
        send_vec(vec2(10, 10));
        idle();
        apply_reset();
        repeat (2 * N + 2) idle();

        // Reset part-way through a load, then a full reload
        load_row(vec2(9, 9));
        #1 check_value("busy_in_load", 64'(bus.busy), 64'(1));
        apply_reset();
        load_row(vec2(10, 20));
        load_row(vec2(30, 40));
        send_vec(vec2(1, 1));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mmu_array.md
MMU_ARRAY -- requirements
Module: mmu_array

Interface
REQ-001 Parameter N, default 2: array rows = columns.
REQ-002 Parameter DW, default 8: activation/weight width, signed two's complement.
REQ-003 Parameter AW, default 16: accumulator/output width, signed, AW >= 2*DW.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 w_load_valid  input  1  weight row offered.
REQ-007 w_load_row  input  N*DW  weight row r; lane j = W[r][j], lane 0 in LSBs.
REQ-008 w_load_ready  output  1  weight row accepted when high with w_load_valid.
REQ-009 a_valid  input  1  activation vector offered.
REQ-010 a_vec  input  N*DW  activation vector; lane i = a[i], lane 0 in LSBs.
REQ-011 a_ready  output  1  vector accepted when high with a_valid.
REQ-012 out_valid  output  1  one-cycle pulse per result vector.
REQ-013 out_vec  output  N*AW  result; lane j = y[j].
REQ-014 busy  output  1  high in LOAD or DRAIN, or while any vector is in flight.

Function
REQ-015 Array is weight-stationary NxN; PE(i,j) holds W[i][j], passes activation right, partial sum down; y[j] = sum over i of a[i]*W[i][j].
REQ-016 FSM states: EMPTY (no weights), READY, DRAIN, LOAD.
REQ-017 EMPTY: w_load_ready=1, a_ready=0; accepted row -> LOAD with row counter = 1.
REQ-018 LOAD: w_load_ready=1, a_ready=0; rows stored in order 0..N-1; acceptance of row N-1 -> READY, counter cleared.
REQ-019 READY: a_ready = !w_load_valid; w_load_ready = 1 only when no vector in flight.
REQ-020 READY with w_load_valid and vectors in flight -> DRAIN; DRAIN: a_ready=0, w_load_ready=0; pipeline empty -> LOAD (row counter 0).
REQ-021 Simultaneous a_valid and w_load_valid in READY: weight load wins, no vector accepted that cycle.
REQ-022 Input skew: lane i delayed i cycles before PE(i,0); output deskew: column j delayed N-1-j cycles; out_vec is registered.
REQ-023 Latency fixed at exactly 2N cycles from acceptance edge to out_valid; one vector accepted per cycle sustained; results in acceptance order.
REQ-024 No output backpressure; out_vec holds last value when out_valid=0.
REQ-025 Products are full 2*DW signed, sign-extended to AW; accumulation wraps modulo 2^AW (see REQ-031).
REQ-026 In-flight tracking counter, width clog2(2N+1); busy derived from state and counter.
REQ-027 Weight registers change only in LOAD; in-flight vectors always use the weights present at their acceptance.

Reset
REQ-028 reset low asynchronously forces state EMPTY, all weights 0, all skew/PE/deskew registers and valid bits 0, row and in-flight counters 0.
REQ-029 During reset: out_valid=0, out_vec=0, a_ready=0, busy=0, w_load_ready=0; w_load_ready=1 from first edge after release.
REQ-030 Reset during LOAD or DRAIN discards partial rows and in-flight vectors; no out_valid is produced for them.

Configuration
REQ-031 Macro MMU_ARRAY_SAT_EN defined: each PE add saturates to [-2^(AW-1), 2^(AW-1)-1]; undefined: two's-complement wrap, no saturation logic.

Verification
REQ-032 N=2, load rows [1,2],[3,4], send a=[5,6] -> out_valid exactly 4 cycles later, out_vec=[23,34], busy low next cycle.
REQ-033 Same weights, vectors [1,0],[0,1],[2,2] back-to-back -> out_valid on 3 consecutive cycles with [1,2],[3,4],[8,12].
REQ-034 W all -128, a=[-128,-128], AW=16 -> y=[32767,32767] with MMU_ARRAY_SAT_EN; [-32768,-32768] without.
REQ-035 Two vectors in flight, assert w_load_valid -> DRAIN, a_ready=0, both results correct with old weights, then w_load_ready=1.
REQ-036 Reset asserted after row 0 of LOAD -> EMPTY, a_ready=0; full reload then a=[1,1] yields column sums of new weights only.
REQ-037 a_valid and w_load_valid same cycle in READY -> a_ready=0, no out_valid generated for that vector.
